// File: rtl/atm_session_ctrl.sv
// ATM session controller: card/PIN/menu sequencing, lockout and
// inactivity timeout, one datapath transaction in flight at a time.
module atm_session_ctrl #(
  parameter int MAX_PIN_TRIES  = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int AMT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             card_in,
  input  logic             pin_valid,
  input  logic             pin_ok,
  input  logic             op_req,
  input  logic [1:0]       op_code,
  input  logic [AMT_W-1:0] amount,
  input  logic [1:0]       language_sel,
  output logic             dp_start,
  output logic [1:0]       dp_op,
  output logic [AMT_W-1:0] dp_amount,
  input  logic             dp_done,
  input  logic             dp_fail,
  input  logic [AMT_W-1:0] dp_balance,
  output logic             ready,
  output logic             error,
  output logic             cash,
  output logic             deposit_complete,
  output logic [AMT_W-1:0] balance,
  output logic             balance_valid,
  output logic [1:0]       language,
  output logic             eject,
  output logic             locked
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PIN,
    S_MENU,
    S_WAIT,
    S_EJECT,
    S_LOCK
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       tries_q, tries_d, tries_inc;
  logic [TW-1:0]    timer_q, timer_d, timer_inc;
  logic             timer_hit;
  logic             gone_q, gone_d;
  logic [1:0]       op_q, op_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic             start_q, start_d;
  logic             err_q, err_d;
  logic             cash_q, cash_d;
  logic             dep_q, dep_d;
  logic [AMT_W-1:0] bal_q, bal_d;
  logic             balv_q, balv_d;
  logic [1:0]       lang_q, lang_d;
  logic             ready_q, eject_q, locked_q;

  assign timer_inc = timer_q + TW'(1);
  assign timer_hit = (timer_inc == TW'(TIMEOUT_CYCLES));
  assign tries_inc = (tries_q == 3'd7) ? tries_q : tries_q + 3'd1;

  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    timer_d = '0;
    gone_d  = gone_q;
    op_d    = op_q;
    amt_d   = amt_q;
    start_d = 1'b0;
    err_d   = 1'b0;
    cash_d  = 1'b0;
    dep_d   = 1'b0;
    bal_d   = bal_q;
    balv_d  = balv_q;
    lang_d  = lang_q;
    unique case (state_q)
      S_IDLE: begin
        if (card_in) begin
          state_d = S_PIN;
          tries_d = '0;
          bal_d   = '0;
          balv_d  = 1'b0;
        end
      end
      S_PIN: begin
        if (!card_in) begin
          state_d = S_IDLE;
        end else if (pin_valid) begin
          if (pin_ok) begin
            state_d = S_MENU;
          end else begin
            tries_d = tries_inc;
            err_d   = 1'b1;
            if (tries_inc >= 3'(MAX_PIN_TRIES))
              state_d = S_LOCK;
          end
        end else if (timer_hit) begin
          state_d = S_EJECT;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_MENU: begin
        if (!card_in) begin
          state_d = S_IDLE;
        end else if (op_req) begin
          if (op_code == 2'b11) begin
            lang_d = language_sel;
          end else if (op_code == 2'b00 && amount == '0) begin
            err_d = 1'b1;
          end else begin
            op_d    = op_code;
            amt_d   = amount;
            start_d = 1'b1;
            gone_d  = 1'b0;
            state_d = S_WAIT;
          end
        end else if (timer_hit) begin
          state_d = S_EJECT;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_WAIT: begin
        // Remember any card pull so the result still completes first.
        gone_d = gone_q | ~card_in;
        if (dp_done) begin
          if (dp_fail) begin
            err_d = 1'b1;
          end else begin
            unique case (op_q)
              2'b00:   cash_d = 1'b1;
              2'b01:   dep_d  = 1'b1;
              2'b10: begin
                bal_d  = dp_balance;
                balv_d = 1'b1;
              end
              default: ;
            endcase
          end
          state_d = (gone_q || !card_in) ? S_EJECT : S_MENU;
        end
      end
      S_EJECT: begin
        if (!card_in)
          state_d = S_IDLE;
      end
      S_LOCK:  state_d = S_LOCK;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tries_q  <= '0;
      timer_q  <= '0;
      gone_q   <= 1'b0;
      op_q     <= '0;
      amt_q    <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      cash_q   <= 1'b0;
      dep_q    <= 1'b0;
      bal_q    <= '0;
      balv_q   <= 1'b0;
      lang_q   <= '0;
      ready_q  <= 1'b0;
      eject_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tries_q  <= tries_d;
      timer_q  <= timer_d;
      gone_q   <= gone_d;
      op_q     <= op_d;
      amt_q    <= amt_d;
      start_q  <= start_d;
      err_q    <= err_d;
      cash_q   <= cash_d;
      dep_q    <= dep_d;
      bal_q    <= bal_d;
      balv_q   <= balv_d;
      lang_q   <= lang_d;
      ready_q  <= (state_d == S_IDLE) || (state_d == S_MENU);
      eject_q  <= (state_d == S_EJECT);
      locked_q <= (state_d == S_LOCK);
    end
  end

  assign dp_start         = start_q;
  assign dp_op            = op_q;
  assign dp_amount        = amt_q;
  assign ready            = ready_q;
  assign error            = err_q;
  assign cash             = cash_q;
  assign deposit_complete = dep_q;
  assign balance          = bal_q;
  assign balance_valid    = balv_q;
  assign language         = lang_q;
  assign eject            = eject_q;
  assign locked           = locked_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Scoreboard bench for atm_session_ctrl: a session-level reference model
// queues the expected outputs; a monitor compares them every cycle.
module tb_atm_session_ctrl;

  localparam int AW   = 16;
  localparam int MAXT = 3;
  localparam int TMO  = 8;

  localparam int M_IDLE  = 0;
  localparam int M_PIN   = 1;
  localparam int M_MENU  = 2;
  localparam int M_WAIT  = 3;
  localparam int M_EJECT = 4;
  localparam int M_LOCK  = 5;

  typedef struct packed {
    logic          ready;
    logic          error;
    logic          cash;
    logic          dep;
    logic          start;
    logic [1:0]    op;
    logic [AW-1:0] amt;
    logic [AW-1:0] bal;
    logic          balv;
    logic [1:0]    lang;
    logic          eject;
    logic          locked;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, card_in, pin_valid, pin_ok, op_req;
  logic [1:0]    op_code, language_sel;
  logic [AW-1:0] amount, dp_balance;
  logic          dp_done, dp_fail;
  logic          dp_start, ready, error, cash, deposit_complete;
  logic [1:0]    dp_op, language;
  logic [AW-1:0] dp_amount, balance;
  logic          balance_valid, eject, locked;

  atm_session_ctrl #(
    .MAX_PIN_TRIES (MAXT),
    .TIMEOUT_CYCLES(TMO),
    .AMT_W         (AW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .card_in         (card_in),
    .pin_valid       (pin_valid),
    .pin_ok          (pin_ok),
    .op_req          (op_req),
    .op_code         (op_code),
    .amount          (amount),
    .language_sel    (language_sel),
    .dp_start        (dp_start),
    .dp_op           (dp_op),
    .dp_amount       (dp_amount),
    .dp_done         (dp_done),
    .dp_fail         (dp_fail),
    .dp_balance      (dp_balance),
    .ready           (ready),
    .error           (error),
    .cash            (cash),
    .deposit_complete(deposit_complete),
    .balance         (balance),
    .balance_valid   (balance_valid),
    .language        (language),
    .eject           (eject),
    .locked          (locked)
  );

  always #5 clk = ~clk;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   active = 1'b1;

  // Session-level reference state
  int            m_st, m_tries, m_idle;
  bit            m_gone, m_balv;
  logic [1:0]    m_op, m_lang;
  logic [AW-1:0] m_amt, m_bal;

  task automatic model_step();
    exp_t e;
    bit er, ca, de, st, ev;
    er = 0; ca = 0; de = 0; st = 0; ev = 0;
    if (reset) begin
      m_st = M_IDLE; m_tries = 0; m_idle = 0; m_gone = 0;
      m_balv = 0; m_op = 0; m_lang = 0; m_amt = 0; m_bal = 0;
      e = '0;
    end else begin
      case (m_st)
        M_IDLE: if (card_in) begin
          m_st = M_PIN; m_tries = 0; m_idle = 0;
          m_bal = 0; m_balv = 0;
        end
        M_PIN: begin
          if (!card_in) m_st = M_IDLE;
          else if (pin_valid) begin
            ev = 1;
            if (pin_ok) m_st = M_MENU;
            else begin
              if (m_tries < 7) m_tries++;
              er = 1;
              if (m_tries >= MAXT) m_st = M_LOCK;
            end
          end
        end
        M_MENU: begin
          if (!card_in) m_st = M_IDLE;
          else if (op_req) begin
            ev = 1;
            if (op_code == 2'b11) m_lang = language_sel;
            else if (op_code == 2'b00 && amount == 0) er = 1;
            else begin
              m_op = op_code; m_amt = amount; st = 1;
              m_gone = 0; m_st = M_WAIT;
            end
          end
        end
        M_WAIT: begin
          if (!card_in) m_gone = 1;
          if (dp_done) begin
            if (dp_fail) er = 1;
            else if (m_op == 2'b00) ca = 1;
            else if (m_op == 2'b01) de = 1;
            else if (m_op == 2'b10) begin
              m_bal = dp_balance; m_balv = 1;
            end
            m_st = m_gone ? M_EJECT : M_MENU;
          end
        end
        M_EJECT: if (!card_in) m_st = M_IDLE;
        default: ;
      endcase
      // Idle-time accounting: any cycle in PIN/MENU without an accepted event
      if (m_st == M_PIN || m_st == M_MENU) begin
        if (ev || st) m_idle = 0;
        else if (er == 0 || ev) begin
          m_idle++;
          if (m_idle >= TMO) begin
            m_st = M_EJECT; er = 1; m_idle = 0;
          end
        end
      end else begin
        m_idle = 0;
      end
      e.ready  = (m_st == M_IDLE) || (m_st == M_MENU);
      e.error  = er;
      e.cash   = ca;
      e.dep    = de;
      e.start  = st;
      e.op     = m_op;
      e.amt    = m_amt;
      e.bal    = m_bal;
      e.balv   = m_balv;
      e.lang   = m_lang;
      e.eject  = (m_st == M_EJECT);
      e.locked = (m_st == M_LOCK);
    end
    expq.push_back(e);
  endtask

  // Entry into PIN/MENU this cycle must start the idle count from zero.
  int prev_st = M_IDLE;

  task automatic tick();
    prev_st = m_st;
    model_step();
    if ((m_st == M_PIN || m_st == M_MENU) && m_st != prev_st)
      m_idle = 0;
    @(negedge clk);
    pin_valid = 0; op_req = 0; dp_done = 0; dp_fail = 0;
  endtask

  exp_t mon_e, mon_got;

  always @(posedge clk) begin
    #2;
    if (active) begin
      cyc++;
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty cyc=%0d got=none required=entry", cyc);
      end else begin
        mon_e   = expq.pop_front();
        mon_got = {ready, error, cash, deposit_complete, dp_start, dp_op,
                   dp_amount, balance, balance_valid, language, eject,
                   locked};
        if (mon_got !== mon_e) begin
          bad++;
          $display("FAIL outputs cyc=%0d got=%p required=%p",
                   cyc, mon_got, mon_e);
        end
      end
    end
  end

  initial begin
    reset = 1; card_in = 0; pin_valid = 0; pin_ok = 0; op_req = 0;
    op_code = 0; amount = 0; language_sel = 0; dp_done = 0;
    dp_fail = 0; dp_balance = 0;
    tick(); tick();
    reset = 0; tick();
    // withdraw
    card_in = 1; tick();
    pin_valid = 1; pin_ok = 1; tick();
    op_req = 1; op_code = 2'b00; amount = 16'd100; tick();
    tick(); tick();
    dp_done = 1; dp_fail = 0; tick();
    tick();
    // balance then failed withdraw
    op_req = 1; op_code = 2'b10; amount = 16'h1234; tick();
    dp_done = 1; dp_balance = 16'h1F40; tick();
    op_req = 1; op_code = 2'b00; amount = 16'hFFFF; tick();
    tick();
    dp_done = 1; dp_fail = 1; dp_balance = 16'h0BAD; tick();
    tick();
    // language, then removal racing a deposit request
    op_req = 1; op_code = 2'b11; language_sel = 2'b10; tick();
    card_in = 0; op_req = 1; op_code = 2'b01; amount = 16'd5; tick();
    tick();
    // removal mid-transaction
    card_in = 1; tick();
    pin_valid = 1; pin_ok = 1; tick();
    op_req = 1; op_code = 2'b01; amount = 16'd7; tick();
    card_in = 0; tick();
    tick();
    dp_done = 1; tick();
    tick(); tick();
    // timeout in MENU
    card_in = 1; tick();
    pin_valid = 1; pin_ok = 1; tick();
    repeat (10) tick();
    card_in = 0; tick();
    tick();
    // lockout
    card_in = 1; tick();
    repeat (MAXT) begin
      pin_valid = 1; pin_ok = 0; tick();
      tick();
    end
    pin_valid = 1; pin_ok = 1; tick();
    card_in = 0; tick();
    card_in = 1; tick();
    reset = 1; tick();
    reset = 0; tick();
    // randomized sessions
    for (int i = 0; i < 2000; i++) begin
      if (m_st == M_LOCK) reset = ($urandom_range(0, 9) == 0);
      else reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 29) == 0) card_in = ~card_in;
      pin_valid    = ($urandom_range(0, 4) == 0);
      pin_ok       = ($urandom_range(0, 2) != 0);
      op_req       = ($urandom_range(0, 3) == 0);
      op_code      = 2'($urandom_range(0, 3));
      amount       = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
      language_sel = 2'($urandom_range(0, 3));
      if (m_st == M_WAIT) dp_done = ($urandom_range(0, 2) == 0);
      else dp_done = ($urandom_range(0, 29) == 0);
      dp_fail    = ($urandom_range(0, 3) == 0);
      dp_balance = AW'($urandom);
      tick();
    end
    active = 0;
    @(posedge clk);
    #5;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d required=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/atm_session_ctrl.md
# atm_session_ctrl

Session controller for the ATM datapath. Tracks one card session: card insertion, PIN attempts with lockout, and menu selection. It issues one transaction at a time to the balance/cash datapath over a start/done handshake and returns the result strobes (cash, deposit_complete, balance, error) to the front panel. It sits between the panel inputs and the existing `modatm` datapath, and it owns the inactivity timeout and the card eject and lock policy.

## Interface
Parameters:
- MAX_PIN_TRIES, 3, wrong-PIN attempts allowed before lockout (1..7)
- TIMEOUT_CYCLES, 1000, idle cycles in PIN/MENU before forced eject (>=2)
- AMT_W, 16, amount/balance width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; sampled on rising clk
- card_in  in  1  card present level
- pin_valid  in  1  one-cycle strobe: PIN entry complete
- pin_ok  in  1  PIN compare result, qualified by pin_valid
- op_req  in  1  one-cycle strobe: menu selection
- op_code  in  2  00 withdraw, 01 deposit, 10 balance inquiry, 11 language
- amount  in  AMT_W  amount for withdraw/deposit, sampled with op_req
- language_sel  in  2  language code, sampled with op_req when op_code=11
- dp_start  out  1  one-cycle strobe to datapath
- dp_op  out  2  registered op_code for the datapath
- dp_amount  out  AMT_W  registered amount
- dp_done  in  1  datapath completion strobe
- dp_fail  in  1  qualified by dp_done; insufficient funds or other failure
- dp_balance  in  AMT_W  balance from datapath, valid with dp_done
- ready  out  1  high in IDLE and MENU
- error  out  1  one-cycle pulse
- cash  out  1  one-cycle pulse: withdraw succeeded
- deposit_complete  out  1  one-cycle pulse: deposit succeeded
- balance  out  AMT_W  last inquiry result
- balance_valid  out  1  balance holds a result for this session
- language  out  2  current language
- eject  out  1  level: card being returned
- locked  out  1  level: card retained, terminal locked

## Operation
- All outputs are registered. Reset values: every output is 0 and the state is IDLE. Reset overrides all other inputs in the cycle it is sampled.
- The FSM has these states: IDLE, PIN, MENU, WAIT, EJECT, LOCK.
- IDLE:
  - ready=1.
  - card_in=1 moves to PIN. On this transition tries=0, timer=0, and balance/balance_valid are cleared.
- PIN:
  - pin_valid with pin_ok=1 moves to MENU.
  - pin_valid with pin_ok=0 increments tries. If tries reaches MAX_PIN_TRIES, error pulses and the FSM moves to LOCK. Otherwise error pulses and the FSM stays in PIN.
- MENU:
  - ready=1.
  - op_req with op_code=11 loads language<=language_sel and stays in MENU. No dp_start is issued.
  - op_req with op_code=00 and amount=0 pulses error and stays in MENU.
  - Any other op_req latches dp_op and dp_amount, pulses dp_start, and moves to WAIT.
- WAIT:
  - On dp_done with dp_fail=1: error pulses.
  - On dp_done with dp_fail=0:
    - op 00: cash pulses.
    - op 01: deposit_complete pulses.
    - op 10: balance<=dp_balance and balance_valid<=1.
  - Either way, the next state is MENU, or EJECT if card_in was seen low at any point during WAIT.
  - op_req and pin_valid are ignored in WAIT. There is no queueing.
- EJECT:
  - eject=1 until card_in=0 is sampled, then IDLE.
- LOCK:
  - locked=1 and eject=0. The FSM stays here until reset, regardless of card_in.
- Card removal (card_in=0) in PIN or MENU moves to IDLE in the next cycle. Removal has priority over a pin_valid or op_req in the same cycle; that strobe is dropped.
- Timeout:
  - The timer counts each cycle spent in PIN or MENU.
  - It is cleared by any accepted pin_valid or op_req, and on entry to PIN or MENU.
  - When the timer reaches TIMEOUT_CYCLES, the FSM moves to EJECT and error pulses.
  - The timer is held at 0 in WAIT.
- language persists across sessions. Only reset returns it to 00.
- tries saturates and never wraps. The timer width is clog2(TIMEOUT_CYCLES+1).

## Timing
- Inputs sampled at edge N produce state and output updates visible after edge N.
- op_req at edge N gives dp_start high for exactly the cycle after N, with dp_op and dp_amount stable from that cycle until the next dp_start.
- dp_done at edge M gives cash, deposit_complete, or error high for the one cycle after M, and balance updated in that same cycle. ready returns 1 in the same cycle.
- Minimum menu-to-menu round trip is 2 cycles (datapath answering dp_done in the cycle after dp_start).
- Wrong PIN at edge N gives error high in cycle N+1. After the final wrong attempt, locked is high from cycle N+1.
- Timeout: with no events since MENU entry at edge E, eject rises after edge E+TIMEOUT_CYCLES.
- Reset asserted during WAIT forces IDLE. Any late dp_done is then ignored, because it is not in WAIT.

## Test plan
- Withdraw path: card_in=1; pin_valid with pin_ok=1; op_req op=00 amount=100; dp_done 3 cycles later with dp_fail=0 -> one dp_start with dp_amount=100, then one cash pulse, then ready=1 in MENU.
- Balance and fail: op=10 with dp_balance=0x1F40 -> balance=0x1F40 and balance_valid=1. Then op=00 amount=0xFFFF with dp_fail=1 -> error pulse, cash stays 0, balance unchanged.
- Lockout: three pin_valid strobes with pin_ok=0 (MAX=3) -> three error pulses, locked=1 after the third. Further pin_valid and card_in toggles have no effect until reset, which clears locked.
- Timeout: set TIMEOUT_CYCLES=8, enter MENU, then no events -> after 8 cycles eject=1 and an error pulse. Dropping card_in -> IDLE, ready=1.
- Language and simultaneity: op=11 with language_sel=10 -> language=10 and no dp_start. Then card_in=0 in the same cycle as op_req op=01 -> no dp_start, state IDLE, language still 10.
- Removal mid-transaction: card_in=0 during WAIT, dp_done arrives later -> the result pulse is still issued, then EJECT with eject=1 for one cycle (card already absent), then IDLE.
